ac97_cmd_sequencer: RTL and testbench

AC97_CMD_SEQUENCER -- requirements
Module: ac97_cmd_sequencer

---
 rtl/ac97_cmd_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_ac97_cmd_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac97_cmd_sequencer.sv
// AC'97 command sequencer: waits for codec ready, settles, issues the init register table, then idles.
// Define AC97_VOL_UPDATE_EN to enable on-demand master-volume writes (VOL_REQ / VOL_ATTEN / VOL_BUSY).
module ac97_cmd_sequencer (
    input  logic        BIT_CLK,
    input  logic        SYSTEM_RESET,
    input  logic [7:0]  count_reg,
    input  logic        CODEC_READY,
    input  logic        VOL_REQ,
    input  logic [4:0]  VOL_ATTEN,
    output logic [19:0] CMD_ADDR,
    output logic [19:0] CMD_DATA,
    output logic        CMD_VALID,
    output logic        INIT_DONE,
    output logic        VOL_BUSY
);

    typedef enum logic [2:0] {
        WAIT_READY = 3'd0,
        SETTLE     = 3'd1,
        SEND       = 3'd2,
        IDLE       = 3'd3
`ifdef AC97_VOL_UPDATE_EN
        ,
        VOL_WRITE  = 3'd4
`endif
    } state_t;

    localparam logic [6:0] MASTER_VOL_REG = 7'h02;

    state_t      state_q, state_d;
    logic [3:0]  settleCnt_q, settleCnt_d;
    logic [1:0]  tableIdx_q, tableIdx_d;
    logic        frameCnt_q, frameCnt_d;
    logic [19:0] cmdAddr_q, cmdAddr_d;
    logic [19:0] cmdData_q, cmdData_d;
    logic        cmdValid_q, cmdValid_d;
    logic        initDone_q, initDone_d;
    logic [1:0]  nextIdx;
    logic        frameBoundary;

`ifdef AC97_VOL_UPDATE_EN
    logic        pending_q, pending_d;
    logic [4:0]  atten_q, atten_d;
    logic        volBusy_q, volBusy_d;
    logic        pendConsume;
`else
    logic        unused_volInputs;
    assign unused_volInputs = ^{VOL_REQ, VOL_ATTEN};
`endif

    assign frameBoundary = (count_reg == 8'hFF);

    function automatic logic [6:0] tableReg(input logic [1:0] idx);
        case (idx)
            2'd0:    tableReg = 7'h02;
            2'd1:    tableReg = 7'h04;
            2'd2:    tableReg = 7'h18;
            default: tableReg = 7'h1A;
        endcase
    endfunction

    function automatic logic [15:0] tableData(input logic [1:0] idx);
        case (idx)
            2'd2:    tableData = 16'h0808;
            default: tableData = 16'h0000;
        endcase
    endfunction

    function automatic logic [19:0] addrWord(input logic [6:0] regIdx);
        addrWord = {1'b0, regIdx, 12'h000};
    endfunction

    function automatic logic [19:0] dataWord(input logic [15:0] regData);
        dataWord = {regData, 4'h0};
    endfunction

`ifdef AC97_VOL_UPDATE_EN
    // Same attenuation on both channels, mute bit kept clear.
    function automatic logic [15:0] volData(input logic [4:0] atten);
        volData = {1'b0, 2'b00, atten, 3'b000, atten};
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        settleCnt_d = settleCnt_q;
        tableIdx_d  = tableIdx_q;
        frameCnt_d  = frameCnt_q;
        cmdAddr_d   = cmdAddr_q;
        cmdData_d   = cmdData_q;
        cmdValid_d  = cmdValid_q;
        initDone_d  = initDone_q;
        nextIdx     = tableIdx_q + 2'd1;
`ifdef AC97_VOL_UPDATE_EN
        pendConsume = 1'b0;
        pending_d   = pending_q;
        atten_d     = atten_q;
        volBusy_d   = volBusy_q;
`endif

        case (state_q)
            WAIT_READY: begin
                if (frameBoundary && CODEC_READY) begin
                    state_d     = SETTLE;
                    settleCnt_d = 4'd0;
                end
            end

            SETTLE: begin
                if (frameBoundary) begin
                    if (settleCnt_q == 4'd15) begin
                        state_d    = SEND;
                        tableIdx_d = 2'd0;
                        frameCnt_d = 1'b0;
                        cmdAddr_d  = addrWord(tableReg(2'd0));
                        cmdData_d  = dataWord(tableData(2'd0));
                        cmdValid_d = 1'b1;
                    end else begin
                        settleCnt_d = settleCnt_q + 4'd1;
                    end
                end
            end

            // frameCnt_q marks the second frame of a command; the next word loads on that boundary.
            SEND: begin
                if (frameBoundary) begin
                    if (!frameCnt_q) begin
                        frameCnt_d = 1'b1;
                    end else begin
                        frameCnt_d = 1'b0;
                        if (tableIdx_q == 2'd3) begin
                            state_d    = IDLE;
                            cmdAddr_d  = '0;
                            cmdData_d  = '0;
                            cmdValid_d = 1'b0;
                            initDone_d = 1'b1;
                        end else begin
                            tableIdx_d = nextIdx;
                            cmdAddr_d  = addrWord(tableReg(nextIdx));
                            cmdData_d  = dataWord(tableData(nextIdx));
                        end
                    end
                end
            end

            IDLE: begin
`ifdef AC97_VOL_UPDATE_EN
                if (frameBoundary && pending_q) begin
                    state_d     = VOL_WRITE;
                    frameCnt_d  = 1'b0;
                    cmdAddr_d   = addrWord(MASTER_VOL_REG);
                    cmdData_d   = dataWord(volData(atten_q));
                    cmdValid_d  = 1'b1;
                    pendConsume = 1'b1;
                end
`endif
            end

`ifdef AC97_VOL_UPDATE_EN
            VOL_WRITE: begin
                if (frameBoundary) begin
                    if (!frameCnt_q) begin
                        frameCnt_d = 1'b1;
                    end else begin
                        frameCnt_d = 1'b0;
                        if (pending_q) begin
                            cmdData_d   = dataWord(volData(atten_q));
                            pendConsume = 1'b1;
                        end else begin
                            state_d    = IDLE;
                            cmdAddr_d  = '0;
                            cmdData_d  = '0;
                            cmdValid_d = 1'b0;
                        end
                    end
                end
            end
`endif

            default: begin
                state_d = WAIT_READY;
            end
        endcase

        // Losing the codec abandons whatever was in flight, but a queued volume request survives.
        if ((state_q != WAIT_READY) && !CODEC_READY) begin
            state_d     = WAIT_READY;
            settleCnt_d = 4'd0;
            tableIdx_d  = 2'd0;
            frameCnt_d  = 1'b0;
            cmdAddr_d   = '0;
            cmdData_d   = '0;
            cmdValid_d  = 1'b0;
            initDone_d  = 1'b0;
`ifdef AC97_VOL_UPDATE_EN
            pendConsume = 1'b0;
`endif
        end

`ifdef AC97_VOL_UPDATE_EN
        // A request landing on the issuing boundary wins the pending slot over the consume.
        if (VOL_REQ) begin
            pending_d = 1'b1;
            atten_d   = VOL_ATTEN;
        end else if (pendConsume) begin
            pending_d = 1'b0;
        end
        volBusy_d = pending_d || (state_d == VOL_WRITE);
`endif
    end

    always_ff @(posedge BIT_CLK) begin
        if (!SYSTEM_RESET) begin
            state_q     <= WAIT_READY;
            settleCnt_q <= 4'd0;
            tableIdx_q  <= 2'd0;
            frameCnt_q  <= 1'b0;
            cmdAddr_q   <= '0;
            cmdData_q   <= '0;
            cmdValid_q  <= 1'b0;
            initDone_q  <= 1'b0;
`ifdef AC97_VOL_UPDATE_EN
            pending_q   <= 1'b0;
            atten_q     <= 5'd0;
            volBusy_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            settleCnt_q <= settleCnt_d;
            tableIdx_q  <= tableIdx_d;
            frameCnt_q  <= frameCnt_d;
            cmdAddr_q   <= cmdAddr_d;
            cmdData_q   <= cmdData_d;
            cmdValid_q  <= cmdValid_d;
            initDone_q  <= initDone_d;
`ifdef AC97_VOL_UPDATE_EN
            pending_q   <= pending_d;
            atten_q     <= atten_d;
            volBusy_q   <= volBusy_d;
`endif
        end
    end

    assign CMD_ADDR  = cmdAddr_q;
    assign CMD_DATA  = cmdData_q;
    assign CMD_VALID = cmdValid_q;
    assign INIT_DONE = initDone_q;
`ifdef AC97_VOL_UPDATE_EN
    assign VOL_BUSY  = volBusy_q;
`else
    assign VOL_BUSY  = 1'b0;
`endif

endmodule

// File: tb/tb_ac97_cmd_sequencer.sv
// Bench for ac97_cmd_sequencer: checkpoint table plus a scoreboard of expected command words,
// popped whenever a new command appears on a frame boundary.
module tb_ac97_cmd_sequencer;

    logic        clk;
    logic        rstN;
    logic [7:0]  countReg;
    logic        codecReady;
    logic        volReq;
    logic [4:0]  volAtten;
    logic [19:0] cmdAddr;
    logic [19:0] cmdData;
    logic        cmdValid;
    logic        initDone;
    logic        volBusy;

    int checks = 0;
    int failures = 0;
    int edgeIdx = -1;
    int holdFrames = 0;
    bit monitorOn = 1'b0;
    logic [47:0] prevState;

    typedef struct {
        logic [19:0] addr;
        logic [19:0] data;
    } cmd_t;

    typedef struct {
        int          atEdge;
        logic        volReq;
        logic [4:0]  atten;
        logic        pushVol;
        logic        expValid;
        logic        expDone;
        logic        expBusy;
        logic [19:0] expAddr;
        logic [19:0] expData;
    } vec_t;

    cmd_t expQ[$];
    vec_t vecs[$];

    ac97_cmd_sequencer dut (
        .BIT_CLK      (clk),
        .SYSTEM_RESET (rstN),
        .count_reg    (countReg),
        .CODEC_READY  (codecReady),
        .VOL_REQ      (volReq),
        .VOL_ATTEN    (volAtten),
        .CMD_ADDR     (cmdAddr),
        .CMD_DATA     (cmdData),
        .CMD_VALID    (cmdValid),
        .INIT_DONE    (initDone),
        .VOL_BUSY     (volBusy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(input int e, input logic rq, input logic [4:0] at, input logic ps,
                                   input logic v, input logic d, input logic b,
                                   input logic [19:0] a, input logic [19:0] dt);
        vec_t r;
        r.atEdge = e; r.volReq = rq; r.atten = at; r.pushVol = ps;
        r.expValid = v; r.expDone = d; r.expBusy = b; r.expAddr = a; r.expData = dt;
        return r;
    endfunction

    function automatic cmd_t mkCmd(input logic [19:0] a, input logic [19:0] d);
        cmd_t c;
        c.addr = a;
        c.data = d;
        return c;
    endfunction

    function automatic cmd_t volCmd(input logic [4:0] at);
        return mkCmd(20'h02000, {1'b0, 2'b00, at, 3'b000, at, 4'h0});
    endfunction

    function automatic logic [47:0] snap();
        return {6'b0, cmdValid, initDone, cmdAddr, cmdData};
    endfunction

    task automatic pushInit();
        expQ.push_back(mkCmd(20'h02000, 20'h00000));
        expQ.push_back(mkCmd(20'h04000, 20'h00000));
        expQ.push_back(mkCmd(20'h18000, 20'h08080));
        expQ.push_back(mkCmd(20'h1A000, 20'h00000));
    endtask

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Commands may only change on a frame boundary and each must live exactly two frames.
    task automatic monitorFrame(input logic fb, input logic steady);
        cmd_t e;
        if (fb) begin
            if (cmdValid) begin
                if (holdFrames == 1) begin
                    checkOutput("hold_cmd", 48'({cmdAddr, cmdData}), 48'(prevState[39:0]));
                    holdFrames = 2;
                end else begin
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL sb_unexpected: got cmd 0x%05h/0x%05h expected no command",
                                 cmdAddr, cmdData);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("sb_addr", 48'(cmdAddr), 48'(e.addr));
                        checkOutput("sb_data", 48'(cmdData), 48'(e.data));
                    end
                    holdFrames = 1;
                end
            end else begin
                if (holdFrames != 0) checkOutput("frames_held", 48'(holdFrames), 48'd2);
                holdFrames = 0;
            end
        end else if (steady) begin
            checkOutput("mid_frame_stable", snap(), prevState);
        end
`ifndef AC97_VOL_UPDATE_EN
        checkOutput("busy_tied_low", 48'(volBusy), 48'd0);
`endif
        prevState = snap();
    endtask

    task automatic stepCycle();
        logic [7:0] sampledCount;
        logic       sampledOk;
        sampledCount = countReg;
        sampledOk = codecReady && rstN;
        @(posedge clk);
        #1;
        edgeIdx++;
        if (monitorOn) monitorFrame(sampledCount == 8'hFF, sampledOk);
        countReg = countReg + 8'd1;
    endtask

    task automatic applyStimulus(input vec_t v, input int n);
        while (edgeIdx < v.atEdge - 1) stepCycle();
        if (v.pushVol) expQ.push_back(volCmd(v.atten));
        volReq = v.volReq;
        volAtten = v.atten;
        stepCycle();
        volReq = 1'b0;
        checkOutput($sformatf("vec%0d_valid", n), 48'(cmdValid), 48'(v.expValid));
        checkOutput($sformatf("vec%0d_done", n), 48'(initDone), 48'(v.expDone));
        checkOutput($sformatf("vec%0d_busy", n), 48'(volBusy), 48'(v.expBusy));
        checkOutput($sformatf("vec%0d_addr", n), 48'(cmdAddr), 48'(v.expAddr));
        checkOutput($sformatf("vec%0d_data", n), 48'(cmdData), 48'(v.expData));
    endtask

    initial begin
        int  waited;
        bit  found;

        // Edge N after reset release samples count_reg == N mod 256; edge 255 is the first boundary.
        vecs.push_back(mkVec(254,  0, 5'h00, 0, 0, 0, 0, 20'h00000, 20'h00000));
        vecs.push_back(mkVec(4350, 0, 5'h00, 0, 0, 0, 0, 20'h00000, 20'h00000));
        vecs.push_back(mkVec(4351, 0, 5'h00, 0, 1, 0, 0, 20'h02000, 20'h00000));
        vecs.push_back(mkVec(4862, 0, 5'h00, 0, 1, 0, 0, 20'h02000, 20'h00000));
        vecs.push_back(mkVec(4863, 0, 5'h00, 0, 1, 0, 0, 20'h04000, 20'h00000));
        vecs.push_back(mkVec(5375, 0, 5'h00, 0, 1, 0, 0, 20'h18000, 20'h08080));
        vecs.push_back(mkVec(5886, 0, 5'h00, 0, 1, 0, 0, 20'h18000, 20'h08080));
        vecs.push_back(mkVec(5887, 0, 5'h00, 0, 1, 0, 0, 20'h1A000, 20'h00000));
        vecs.push_back(mkVec(6398, 0, 5'h00, 0, 1, 0, 0, 20'h1A000, 20'h00000));
        vecs.push_back(mkVec(6399, 0, 5'h00, 0, 0, 1, 0, 20'h00000, 20'h00000));
`ifdef AC97_VOL_UPDATE_EN
        vecs.push_back(mkVec(6410, 1, 5'h0A, 1, 0, 1, 1, 20'h00000, 20'h00000));
        vecs.push_back(mkVec(6655, 0, 5'h00, 0, 1, 1, 1, 20'h02000, 20'h0A0A0));
        vecs.push_back(mkVec(6700, 1, 5'h1F, 0, 1, 1, 1, 20'h02000, 20'h0A0A0));
        vecs.push_back(mkVec(6800, 1, 5'h03, 1, 1, 1, 1, 20'h02000, 20'h0A0A0));
        vecs.push_back(mkVec(7166, 0, 5'h00, 0, 1, 1, 1, 20'h02000, 20'h0A0A0));
        vecs.push_back(mkVec(7167, 0, 5'h00, 0, 1, 1, 1, 20'h02000, 20'h03030));
        vecs.push_back(mkVec(7678, 0, 5'h00, 0, 1, 1, 1, 20'h02000, 20'h03030));
        vecs.push_back(mkVec(7679, 0, 5'h00, 0, 0, 1, 0, 20'h00000, 20'h00000));
        vecs.push_back(mkVec(7700, 1, 5'h05, 1, 0, 1, 1, 20'h00000, 20'h00000));
        vecs.push_back(mkVec(7935, 1, 5'h07, 1, 1, 1, 1, 20'h02000, 20'h05050));
        vecs.push_back(mkVec(8447, 0, 5'h00, 0, 1, 1, 1, 20'h02000, 20'h07070));
        vecs.push_back(mkVec(8959, 0, 5'h00, 0, 0, 1, 0, 20'h00000, 20'h00000));
`else
        vecs.push_back(mkVec(6410, 1, 5'h0A, 0, 0, 1, 0, 20'h00000, 20'h00000));
        vecs.push_back(mkVec(6700, 0, 5'h00, 0, 0, 1, 0, 20'h00000, 20'h00000));
        vecs.push_back(mkVec(6911, 0, 5'h00, 0, 0, 1, 0, 20'h00000, 20'h00000));
`endif

        rstN = 1'b0;
        codecReady = 1'b1;
        volReq = 1'b1;
        volAtten = 5'h15;
        countReg = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        volReq = 1'b0;
        checkOutput("reset_addr", 48'(cmdAddr), 48'd0);
        checkOutput("reset_data", 48'(cmdData), 48'd0);
        checkOutput("reset_valid", 48'(cmdValid), 48'd0);
        checkOutput("reset_done", 48'(initDone), 48'd0);
        checkOutput("reset_busy", 48'(volBusy), 48'd0);

        prevState = snap();
        rstN = 1'b1;
        monitorOn = 1'b1;
        pushInit();
        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Knock the codec out of IDLE so the table restarts, then drop it again mid-table.
        codecReady = 1'b0;
        stepCycle();
        codecReady = 1'b1;
        checkOutput("drop_idle_done", 48'(initDone), 48'd0);
        holdFrames = 0;
        pushInit();
        found = 1'b0;
        for (int b = 0; b < 8000 && !found; b++) begin
            stepCycle();
            if (cmdValid && cmdAddr == 20'h18000) found = 1'b1;
        end
        checkOutput("reach_idx2", 48'(found), 48'd1);
        repeat (100) stepCycle();

        codecReady = 1'b0;
`ifdef AC97_VOL_UPDATE_EN
        volReq = 1'b1;
        volAtten = 5'h0C;
`endif
        stepCycle();
        volReq = 1'b0;
        checkOutput("abort_valid", 48'(cmdValid), 48'd0);
        checkOutput("abort_done", 48'(initDone), 48'd0);
        checkOutput("abort_addr", 48'(cmdAddr), 48'd0);
        checkOutput("abort_data", 48'(cmdData), 48'd0);
`ifdef AC97_VOL_UPDATE_EN
        checkOutput("abort_busy", 48'(volBusy), 48'd1);
`endif
        checkOutput("abort_leftover", 48'(expQ.size()), 48'd1);
        expQ.delete();
        holdFrames = 0;
        repeat (3) stepCycle();

        codecReady = 1'b1;
        pushInit();
`ifdef AC97_VOL_UPDATE_EN
        expQ.push_back(volCmd(5'h0C));
`endif
        waited = 0;
        found = 1'b0;
        while (!found && waited < 5000) begin
            stepCycle();
            waited++;
            if (cmdValid) found = 1'b1;
        end
        checkOutput("restart_seen", 48'(found), 48'd1);
        checkOutput("restart_full_settle", 48'(waited >= 4097 && waited <= 4352), 48'd1);

        found = 1'b0;
        for (int b = 0; b < 3000 && !found; b++) begin
            stepCycle();
            if (initDone) found = 1'b1;
        end
        checkOutput("restart_done", 48'(found), 48'd1);
        repeat (1100) stepCycle();
        checkOutput("end_valid", 48'(cmdValid), 48'd0);
        checkOutput("end_busy", 48'(volBusy), 48'd0);
        checkOutput("sb_leftover", 48'(expQ.size()), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
